// File: rtl/lenet_display_sequencer.sv
// Frame-synchronous sequencer for one LeNet classification pass: arms on a start
// request, freezes camera writes for a frame, starts LeNet, then holds the digit overlay.
module lenet_display_sequencer #(
   parameter int unsigned HOLD_FRAMES   = 60,
   parameter int unsigned LENET_TIMEOUT = 2000000,
   parameter logic        vsync_active  = 1'b0
) (
   input  logic clk24,
   input  logic rst,
   input  logic vga_vsync,
   input  logic start_req,
   input  logic bound_en,
   input  logic lenet_ready,
   output logic lenet_start,
   output logic capture_freeze,
   output logic bound_doing,
   output logic lenet_doing,
   output logic busy,
   output logic timeout_err
);

   localparam int TW = (LENET_TIMEOUT > 1) ? $clog2(LENET_TIMEOUT) : 1;
   localparam int FW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LENET_TIMEOUT - 1);
   localparam logic [FW-1:0] HOLD_LAST    = FW'(HOLD_FRAMES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_FREEZE,
      S_RUN,
      S_SHOW
   } state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic            r_vsyncQ;
   logic            r_startReqQ;
   logic [TW-1:0]   r_runCnt;
   logic [FW-1:0]   r_frameCnt;
   logic            r_lenetStart;
   logic            r_captureFreeze;
   logic            r_boundDoing;
   logic            r_lenetDoing;
   logic            r_busy;
   logic            r_timeoutErr;
   logic            w_frameTick;
   logic            w_startPulse;
   logic            w_runExpired;
   logic            w_holdDone;

   // The edge detector resets high so a request held through reset never fires.
   always_ff @(posedge clk24 or posedge rst) begin
      if (rst) begin
         r_vsyncQ    <= ~vsync_active;
         r_startReqQ <= 1'b1;
      end else begin
         r_vsyncQ    <= vga_vsync;
         r_startReqQ <= start_req;
      end
   end

   assign w_frameTick  = (r_vsyncQ != vsync_active) && (vga_vsync == vsync_active);
   assign w_startPulse = start_req & ~r_startReqQ;
   assign w_runExpired = (r_runCnt == TIMEOUT_LAST);
   assign w_holdDone   = w_frameTick && (r_frameCnt == HOLD_LAST);

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:   if (w_startPulse) w_nextState = S_ARMED;
         S_ARMED:  if (w_frameTick) w_nextState = S_FREEZE;
         S_FREEZE: if (w_frameTick) w_nextState = S_RUN;
         S_RUN: begin
            if (lenet_ready) begin
               w_nextState = S_SHOW;
            end else if (w_runExpired) begin
               w_nextState = S_IDLE;
            end
         end
         S_SHOW:   if (w_holdDone) w_nextState = S_IDLE;
         default:  w_nextState = S_IDLE;
      endcase
   end

   // Outputs are decoded from the destination state so they change on the same
   // edge as the state register.
   always_ff @(posedge clk24 or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_runCnt        <= '0;
         r_frameCnt      <= '0;
         r_lenetStart    <= 1'b0;
         r_captureFreeze <= 1'b0;
         r_boundDoing    <= 1'b0;
         r_lenetDoing    <= 1'b0;
         r_busy          <= 1'b0;
         r_timeoutErr    <= 1'b0;
      end else begin
         r_state <= w_nextState;

         if (r_state == S_RUN && w_nextState == S_RUN) begin
            r_runCnt <= r_runCnt + TW'(1);
         end else begin
            r_runCnt <= '0;
         end

         if (r_state == S_SHOW && w_nextState == S_SHOW) begin
            if (w_frameTick) begin
               r_frameCnt <= r_frameCnt + FW'(1);
            end
         end else begin
            r_frameCnt <= '0;
         end

         if (r_state == S_IDLE && w_startPulse) begin
            r_timeoutErr <= 1'b0;
         end else if (r_state == S_RUN && !lenet_ready && w_runExpired) begin
            r_timeoutErr <= 1'b1;
         end

         r_lenetStart    <= (r_state == S_FREEZE) && (w_nextState == S_RUN);
         r_captureFreeze <= (w_nextState == S_FREEZE) || (w_nextState == S_RUN);
         r_boundDoing    <= bound_en && (w_nextState != S_SHOW);
         r_lenetDoing    <= (w_nextState == S_SHOW);
         r_busy          <= (w_nextState != S_IDLE);
      end
   end

   assign lenet_start    = r_lenetStart;
   assign capture_freeze = r_captureFreeze;
   assign bound_doing    = r_boundDoing;
   assign lenet_doing    = r_lenetDoing;
   assign busy           = r_busy;
   assign timeout_err    = r_timeoutErr;

endmodule
